melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Sequential player that walks a combinational melody table (select + note index in, tone/length/silence out) note by note.
- Times each note in beats and emits the current tone with a sound enable to the tone decoder / audio generator.
- Generalises the fixed-table jukebox with parametrised index width and tempo, inter-note articulation gap, loop mode, pause, stop, and preemptive restart.
- Sits between game-event logic (start requests) and the table + tone decoder.

Parameters:
- IDX_W, 5: note index width; melody holds at most 2^IDX_W notes.
- SEL_W, 4: melody select width.
- LEN_W, 4: note length width, in beats; 0 = end of melody.
- CLKS_PER_BEAT, 12500000: clock cycles per beat; must be ≥ 1.
- GAP_CLKS, 0: silent cycles inserted after each note; 0 = no gap.
- PREEMPT, 1: 1 = start while busy restarts; 0 = start while busy is ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to play melody_sel.
- melody_sel  in  SEL_W  melody requested with start.
- loop_en  in  1  sampled with start; replay from note 0 at end of melody.
- stop  in  1  abort playback.
- pause  in  1  level; freeze timing and mute while high.
- tbl_tone  in  4  tone from the table for the current select/index.
- tbl_len  in  LEN_W  length from the table.
- tbl_silenceN  in  1  0 = the table note is a rest.
- tbl_sel  out  SEL_W  latched melody select driven to the table.
- tbl_idx  out  IDX_W  note index driven to the table.
- tone  out  4  latched tone of the playing note.
- sound_en  out  1  audio enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on natural end of a non-looping melody.

Behaviour:
- Reset: state IDLE; tbl_sel=0, tbl_idx=0, tone=0, sound_en=0, busy=0, done=0; all counters 0. Reset overrides every other input, including mid-note.
- All outputs registered. The table is combinational; tbl_len, tbl_tone and tbl_silenceN are valid in the same cycle as tbl_idx.
- Input priority per cycle: reset > stop > start > pause.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE + start: latch tbl_sel=melody_sel and loop_q=loop_en; set tbl_idx=0; go to LOAD.
- LOAD (one cycle, sound_en=0):
  - If tbl_len≠0: latch tone=tbl_tone and rest_q=!tbl_silenceN; load beats=tbl_len and beat_cnt=0; go to PLAY.
  - If tbl_len=0, loop_q=1 and tbl_idx≠0: set tbl_idx=0 and stay in LOAD.
  - If tbl_len=0 otherwise (non-looping, or an empty melody at index 0): go to IDLE and pulse done for 1 cycle.
- PLAY:
  - sound_en = !rest_q && !pause.
  - beat_cnt counts 0..CLKS_PER_BEAT-1 and wraps; on wrap, beats decrements.
  - On the final wrap (beats=1): go to GAP if GAP_CLKS>0, else advance.
  - A note of length L gives L×CLKS_PER_BEAT cycles of sound_en=1 when not paused.
- GAP: sound_en=0; count GAP_CLKS cycles, then advance.
- Advance:
  - If tbl_idx = 2^IDX_W−1, treat as end of melody: apply the LOAD end rule without re-reading the table.
  - Otherwise tbl_idx+1 and go to LOAD.
- pause=1: beat_cnt, beats and the gap counter hold; sound_en=0; the state machine holds, including in LOAD. On release, timing resumes exactly where it stopped.
- stop: next cycle IDLE, sound_en=0, busy=0, no done pulse. Ignored in IDLE.
- start while busy:
  - PREEMPT=1: same actions as start in IDLE (relatch tbl_sel/loop_q, tbl_idx=0, go to LOAD, sound_en=0 next cycle); no done for the aborted melody.
  - PREEMPT=0: ignored.
- Simultaneous done and start: IDLE accepts start in the following cycle only; a start coinciding with the end-LOAD is a busy start and follows the PREEMPT rule.
- Arithmetic: beats is LEN_W bits; beat_cnt is $clog2(CLKS_PER_BEAT) bits (minimum 1); gap counter is $clog2(GAP_CLKS+1) bits. No counter overflows for legal parameters.

Test Plan:
1. CLKS_PER_BEAT=4, GAP_CLKS=0; table {len 2, len 1, len 0}; start at cycle 0 → LOAD at cycle 1, sound_en high cycles 2–9, LOAD at 10, sound_en 11–14, LOAD at 15, done=1 at cycle 16, busy=0 at 16.
2. Same table, GAP_CLKS=2 → each note is followed by 2 cycles of sound_en=0 plus a 1-cycle LOAD; tone changes only on the LOAD→PLAY edge.
3. loop_en=1 with 2-note melody → after the len-0 entry tbl_idx returns to 0, no done pulse, sound repeats indefinitely; stop → sound_en=0 and busy=0 next cycle, done stays 0.
4. pause held 5 cycles mid-note with beat_cnt=2, beats=1 → sound_en=0 for 5 cycles; after release the note ends 2 cycles later (total audible cycles unchanged).
5. PREEMPT=1, start with melody_sel=3 during note 4 of melody 1 → tbl_sel=3, tbl_idx=0 next cycle, no done; PREEMPT=0 → playback of melody 1 unaffected.
6. Edge cases:
   - Rest note (tbl_silenceN=0, len 3) → sound_en=0 for 12 cycles while busy=1.
   - Empty melody (len 0 at idx 0, loop_en=1) → done pulse, return to IDLE.
   - IDX_W=2 full 4-note table with no terminator → ends after idx 3.
   - reset asserted mid-PLAY → all outputs zero next cycle.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a combinational melody table note by note, timing each
// note in beats (CLKS_PER_BEAT clocks each) with an optional silent gap afterwards.
// Supports loop mode, pause (freeze + mute), stop, and optional preemptive restart.
module melody_sequencer #(
  parameter int IDX_W         = 5,
  parameter int SEL_W         = 4,
  parameter int LEN_W         = 4,
  parameter int CLKS_PER_BEAT = 12500000,
  parameter int GAP_CLKS      = 0,
  parameter int PREEMPT       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] melody_sel,
  input  logic             loop_en,
  input  logic             stop,
  input  logic             pause,
  input  logic [3:0]       tbl_tone,
  input  logic [LEN_W-1:0] tbl_len,
  input  logic             tbl_silenceN,
  output logic [SEL_W-1:0] tbl_sel,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [3:0]       tone,
  output logic             sound_en,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = (CLKS_PER_BEAT > 1) ? $clog2(CLKS_PER_BEAT) : 1;
  localparam int GC_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CLKS_PER_BEAT - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] tbl_sel_q, tbl_sel_d;
  logic [IDX_W-1:0] tbl_idx_q, tbl_idx_d;
  logic [3:0]       tone_q, tone_d;
  logic             sound_en_q, sound_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             loop_q, loop_d;
  logic             rest_q, rest_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             advance;
  logic             end_mel;

  // Next-state logic: stop beats start beats pause; pause freezes every counter.
  always_comb begin
    state_d    = state_q;
    tbl_sel_d  = tbl_sel_q;
    tbl_idx_d  = tbl_idx_q;
    tone_d     = tone_q;
    loop_d     = loop_q;
    rest_d     = rest_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    advance    = 1'b0;
    end_mel    = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else if (start && ((state_q == S_IDLE) || (PREEMPT != 0))) begin
      tbl_sel_d = melody_sel;
      loop_d    = loop_en;
      tbl_idx_d = '0;
      state_d   = S_LOAD;
    end else if (!pause) begin
      case (state_q)
        S_LOAD: begin
          if (tbl_len != '0) begin
            tone_d     = tbl_tone;
            rest_d     = !tbl_silenceN;
            beats_d    = tbl_len;
            beat_cnt_d = '0;
            state_d    = S_PLAY;
          end else begin
            end_mel = 1'b1;
          end
        end
        S_PLAY: begin
          if (beat_cnt_q == BC_LAST) begin
            beat_cnt_d = '0;
            beats_d    = beats_q - LEN_ONE;
            if (beats_q == LEN_ONE) begin
              if (GAP_CLKS > 0) begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
              end else begin
                advance = 1'b1;
              end
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GC_LAST) begin
            advance = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase

      // The last table slot has no successor, so it ends the melody without a table read.
      if (advance) begin
        if (tbl_idx_q == IDX_LAST) begin
          end_mel = 1'b1;
        end else begin
          tbl_idx_d = tbl_idx_q + 1'b1;
          state_d   = S_LOAD;
        end
      end

      // An empty melody at index 0 cannot loop, otherwise it would spin in LOAD forever.
      if (end_mel) begin
        if (loop_q && (tbl_idx_q != '0)) begin
          tbl_idx_d = '0;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    sound_en_d = (state_d == S_PLAY) && !rest_d && !pause;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tbl_sel_q  <= '0;
      tbl_idx_q  <= '0;
      tone_q     <= '0;
      sound_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loop_q     <= 1'b0;
      rest_q     <= 1'b0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tbl_sel_q  <= tbl_sel_d;
      tbl_idx_q  <= tbl_idx_d;
      tone_q     <= tone_d;
      sound_en_q <= sound_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      rest_q     <= rest_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign tbl_sel  = tbl_sel_q;
  assign tbl_idx  = tbl_idx_q;
  assign tone     = tone_q;
  assign sound_en = sound_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances share stimulus.
// A: IDX_W=3, 4 clk/beat, 2-clk gap, preemptive.  B: IDX_W=2, 4 clk/beat, no gap, non-preemptive.
module tb_melody_sequencer;

  localparam int CPB   = 4;
  localparam int GAP_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, loop_en = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] melody_sel = '0;

  int len_mem  [0:15][0:7];
  int tone_mem [0:15][0:7];
  bit sil_mem  [0:15][0:7];

  logic [3:0] tbl_sel_a, tone_a, tbl_tone_a, tbl_len_a;
  logic [2:0] tbl_idx_a;
  logic       snd_a, busy_a, done_a, tbl_sn_a;
  logic [3:0] tbl_sel_b, tone_b, tbl_tone_b, tbl_len_b;
  logic [1:0] tbl_idx_b;
  logic       snd_b, busy_b, done_b, tbl_sn_b;

  always_comb begin
    tbl_len_a  = 4'(len_mem[tbl_sel_a][tbl_idx_a]);
    tbl_tone_a = 4'(tone_mem[tbl_sel_a][tbl_idx_a]);
    tbl_sn_a   = sil_mem[tbl_sel_a][tbl_idx_a];
    tbl_len_b  = 4'(len_mem[tbl_sel_b][tbl_idx_b]);
    tbl_tone_b = 4'(tone_mem[tbl_sel_b][tbl_idx_b]);
    tbl_sn_b   = sil_mem[tbl_sel_b][tbl_idx_b];
  end

  melody_sequencer #(.IDX_W(3), .SEL_W(4), .LEN_W(4), .CLKS_PER_BEAT(CPB),
                     .GAP_CLKS(GAP_A), .PREEMPT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .melody_sel(melody_sel), .loop_en(loop_en),
    .stop(stop), .pause(pause), .tbl_tone(tbl_tone_a), .tbl_len(tbl_len_a),
    .tbl_silenceN(tbl_sn_a), .tbl_sel(tbl_sel_a), .tbl_idx(tbl_idx_a), .tone(tone_a),
    .sound_en(snd_a), .busy(busy_a), .done(done_a));

  melody_sequencer #(.IDX_W(2), .SEL_W(4), .LEN_W(4), .CLKS_PER_BEAT(CPB),
                     .GAP_CLKS(0), .PREEMPT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .melody_sel(melody_sel), .loop_en(loop_en),
    .stop(stop), .pause(pause), .tbl_tone(tbl_tone_b), .tbl_len(tbl_len_b),
    .tbl_silenceN(tbl_sn_b), .tbl_sel(tbl_sel_b), .tbl_idx(tbl_idx_b), .tone(tone_b),
    .sound_en(snd_b), .busy(busy_b), .done(done_b));

  // Reference model: phase 0 idle, 1 load, 2 play, 3 gap; rem = clocks left in the phase.
  typedef struct {
    int st; int rem; int idx; int sel; bit lp; bit rest; int tone;
    bit snd; bit busy; bit done;
  } mdl_t;
  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int gap, bit pre, int nidx);
    bit endm;
    int len;
    endm   = 1'b0;
    m.done = 1'b0;
    if (reset) begin
      m = '{default: 0};
    end else if (stop && m.st != 0) begin
      m.st = 0;
    end else if (start && (m.st == 0 || pre)) begin
      m.sel = int'(melody_sel);
      m.lp  = loop_en;
      m.idx = 0;
      m.st  = 1;
    end else if (!pause) begin
      if (m.st == 1) begin
        len = len_mem[m.sel][m.idx];
        if (len != 0) begin
          m.tone = tone_mem[m.sel][m.idx];
          m.rest = !sil_mem[m.sel][m.idx];
          m.rem  = len * CPB;
          m.st   = 2;
        end else begin
          endm = 1'b1;
        end
      end else if (m.st == 2 || m.st == 3) begin
        m.rem = m.rem - 1;
        if (m.rem == 0) begin
          if (m.st == 2 && gap > 0) begin
            m.st  = 3;
            m.rem = gap;
          end else if (m.idx == nidx - 1) begin
            endm = 1'b1;
          end else begin
            m.idx = m.idx + 1;
            m.st  = 1;
          end
        end
      end
      if (endm) begin
        if (m.lp && m.idx != 0) begin
          m.idx = 0;
          m.st  = 1;
        end else begin
          m.st   = 0;
          m.done = 1'b1;
        end
      end
    end
    m.snd  = (m.st == 2) && !m.rest && !pause;
    m.busy = (m.st != 0);
    return m;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: advance models with the pre-edge inputs, then compare both DUTs.
  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, GAP_A, 1'b1, 8);
    mb = mstep(mb, 0, 1'b0, 4);
    #1;
    chk("A.tbl_sel", tbl_sel_a, ma.sel);  chk("B.tbl_sel", tbl_sel_b, mb.sel);
    chk("A.tbl_idx", tbl_idx_a, ma.idx);  chk("B.tbl_idx", tbl_idx_b, mb.idx);
    chk("A.tone", tone_a, ma.tone);       chk("B.tone", tone_b, mb.tone);
    chk("A.sound_en", snd_a, ma.snd);     chk("B.sound_en", snd_b, mb.snd);
    chk("A.busy", busy_a, ma.busy);       chk("B.busy", busy_b, mb.busy);
    chk("A.done", done_a, ma.done);       chk("B.done", done_b, mb.done);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input int sel, input bit lp);
    melody_sel = 4'(sel); loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0; loop_en = 1'b0;
  endtask

  typedef struct {
    bit st; int sel; bit lp; bit sp; bit ps;
    bit e_snd; bit e_busy; bit e_done; int e_idx; bit e_done_a;
  } vec_t;
  vec_t vt[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, dn_a, dn_b, seen;
    ma = '{default: 0};
    mb = '{default: 0};

    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 8; i++) begin
        len_mem[s][i]  = $urandom_range(0, 5);
        tone_mem[s][i] = $urandom_range(0, 15);
        sil_mem[s][i]  = ($urandom_range(0, 3) != 0);
      end
    for (int s = 1; s <= 7; s++)
      for (int i = 0; i < 8; i++) begin
        len_mem[s][i] = 0; tone_mem[s][i] = (s + i) % 16; sil_mem[s][i] = 1'b1;
      end
    len_mem[1][0] = 2; len_mem[1][1] = 1;
    len_mem[2][0] = 1; len_mem[2][1] = 2;
    len_mem[3][0] = 1; len_mem[3][1] = 2;
    for (int i = 0; i < 6; i++) len_mem[4][i] = 3;
    len_mem[5][0] = 3; sil_mem[5][0] = 1'b0; len_mem[5][1] = 1;
    for (int i = 0; i < 8; i++) len_mem[7][i] = 1;

    // Melody 1 {2,1,0}: expected per-cycle outputs of B (no gap), plus A's done (2-clk gap).
    vt.push_back('{1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0});
    for (int k = 1; k <= 8; k++)  vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0});
    for (int k = 10; k <= 13; k++) vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0});
    for (int k = 16; k <= 18; k++) vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0});
    vt.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1});

    do_reset();
    chk("reset.busy", busy_a, 0); chk("reset.tone", tone_b, 0);

    foreach (vt[k]) begin
      start = vt[k].st; melody_sel = 4'(vt[k].sel); loop_en = vt[k].lp;
      stop = vt[k].sp; pause = vt[k].ps;
      tick();
      chk("vec.sound_en_b", snd_b, vt[k].e_snd);
      chk("vec.busy_b", busy_b, vt[k].e_busy);
      chk("vec.done_b", done_b, vt[k].e_done);
      chk("vec.idx_b", tbl_idx_b, vt[k].e_idx);
      chk("vec.done_a", done_a, vt[k].e_done_a);
    end
    start = 1'b0;

    // Pause 5 clocks at beat_cnt=2, beats=1 of melody 1's first note; audible total stays 12.
    do_reset();
    do_start(1, 1'b0);
    cnt_a = 0; cnt_b = 0; dn_a = 0; dn_b = 0;
    for (int c = 0; c < 40; c++) begin
      pause = (c >= 7 && c < 12);
      tick();
      if (c == 12) begin chk("pause.still_playing", snd_b, 1); chk("pause.idx_hold", tbl_idx_b, 0); end
      if (c == 13) begin chk("pause.ends_2_after", snd_b, 0); chk("pause.next_idx", tbl_idx_b, 1); end
      cnt_a += int'(snd_a); cnt_b += int'(snd_b);
      dn_a += int'(done_a); dn_b += int'(done_b);
    end
    pause = 1'b0;
    chk("pause.audible_a", cnt_a, 12); chk("pause.audible_b", cnt_b, 12);
    chk("pause.done_a", dn_a, 1);      chk("pause.done_b", dn_b, 1);

    // Looping 2-note melody, then stop.
    do_start(2, 1'b1);
    dn_a = 0; dn_b = 0; cnt_b = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      dn_a += int'(done_a); dn_b += int'(done_b); cnt_b += int'(snd_b);
    end
    chk("loop.no_done_a", dn_a, 0); chk("loop.no_done_b", dn_b, 0);
    chk("loop.still_busy_b", busy_b, 1);
    chk("loop.audible_b_min", int'(cnt_b > 24), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop.snd_a", snd_a, 0); chk("stop.busy_a", busy_a, 0); chk("stop.done_a", done_a, 0);
    chk("stop.snd_b", snd_b, 0); chk("stop.busy_b", busy_b, 0); chk("stop.done_b", done_b, 0);
    tick();
    chk("stop.done_after", int'(done_a | done_b), 0);

    // Preempt: restart A with melody 3 while on note 4 of melody 4; B must ignore it.
    do_start(4, 1'b0);
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      tick();
      if (tbl_idx_a == 3'd3 && snd_a) seen = 1;
    end
    chk("preempt.reached_note4", seen, 1);
    melody_sel = 4'd3; start = 1'b1; tick(); start = 1'b0;
    chk("preempt.sel_a", tbl_sel_a, 3); chk("preempt.idx_a", tbl_idx_a, 0);
    chk("preempt.snd_a", snd_a, 0);     chk("preempt.done_a", done_a, 0);
    chk("preempt.sel_b", tbl_sel_b, 4); chk("preempt.busy_b", busy_b, 1);
    for (int c = 0; c < 40; c++) tick();

    // Rest note: 12 silent but busy clocks on B.
    do_reset();
    do_start(5, 1'b0);
    cnt_b = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      cnt_b += int'(!snd_b && busy_b);
    end
    chk("rest.silent_busy_b", cnt_b, 12);
    for (int c = 0; c < 30; c++) tick();

    // Empty melody with loop_en: one done pulse straight after LOAD.
    do_start(6, 1'b1);
    chk("empty.load_busy", busy_b, 1);
    tick();
    chk("empty.done_a", done_a, 1); chk("empty.busy_a", busy_a, 0);
    chk("empty.done_b", done_b, 1); chk("empty.busy_b", busy_b, 0);

    // Full table with no terminator: B ends after idx 3, A after idx 7.
    do_start(7, 1'b0);
    dn_a = 0; dn_b = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (done_b) begin dn_b++; chk("full.end_idx_b", tbl_idx_b, 3); end
      if (done_a) begin dn_a++; chk("full.end_idx_a", tbl_idx_a, 7); end
    end
    chk("full.done_b", dn_b, 1); chk("full.done_a", dn_a, 1);

    // Reset in the middle of a note.
    do_start(1, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    chk("midreset.playing", snd_a, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset.sel", tbl_sel_a, 0); chk("midreset.idx", tbl_idx_a, 0);
    chk("midreset.tone", tone_a, 0);   chk("midreset.snd", snd_a, 0);
    chk("midreset.busy", busy_a, 0);   chk("midreset.done", done_a, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 29) == 0);
      melody_sel = 4'($urandom_range(0, 15));
      loop_en    = ($urandom_range(0, 1) == 1);
      stop       = ($urandom_range(0, 199) == 0);
      pause      = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
